// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// The STAGE state is only reachable when MULT_SHARE_PIPE_EN is defined.
package mult_share_pkg;
  localparam int MAX_REQ = 8;
  localparam int OPW     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_STAGE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;
endpackage

// File: rtl/Multiplier_8.sv
// Combinational unsigned 8x8 multiplier with a full 16-bit product.
module Multiplier_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts at last_grant+1 and wraps.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one Multiplier_8 among NUM_REQ requesters.
// Define MULT_SHARE_PIPE_EN to insert a STAGE state that registers the product.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [OPW*NUM_REQ-1:0] a_flat,
  input  logic [OPW*NUM_REQ-1:0] b_flat,
  output logic [NUM_REQ-1:0]     ack,
  output logic [15:0]            p,
  output logic [ID_W-1:0]        p_id,
  output logic                   busy
);
  state_e            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   p_id_q, p_id_d;
  logic [15:0]       p_q, p_d;
  logic [15:0]       mult_p;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
`ifdef MULT_SHARE_PIPE_EN
  logic [15:0]       stage_q, stage_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  Multiplier_8 u_mult (
    .a (a_q),
    .b (b_q),
    .p (mult_p)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    last_grant_d = last_grant_q;
    p_d          = p_q;
    p_id_d       = p_id_q;
`ifdef MULT_SHARE_PIPE_EN
    stage_d      = stage_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          a_d          = a_flat[OPW*pick_idx +: OPW];
          b_d          = b_flat[OPW*pick_idx +: OPW];
          last_grant_d = pick_idx;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
`ifdef MULT_SHARE_PIPE_EN
        stage_d = mult_p;
        state_d = ST_STAGE;
`else
        // p/p_id load on entry to RESP so they are valid alongside ack.
        p_d     = mult_p;
        p_id_d  = last_grant_q;
        state_d = ST_RESP;
`endif
      end
      ST_STAGE: begin
`ifdef MULT_SHARE_PIPE_EN
        p_d     = stage_q;
        p_id_d  = last_grant_q;
        state_d = ST_RESP;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      p_q          <= '0;
      p_id_q       <= '0;
`ifdef MULT_SHARE_PIPE_EN
      stage_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      last_grant_q <= last_grant_d;
      p_q          <= p_d;
      p_id_q       <= p_id_d;
`ifdef MULT_SHARE_PIPE_EN
      stage_q      <= stage_d;
`endif
    end
  end

  assign ack  = (state_q == ST_RESP) ? (NUM_REQ'(1) << p_id_q) : '0;
  assign p    = p_q;
  assign p_id = p_id_q;
  assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NUM_REQ=4).
module tb_mult_share_arbiter;
`ifdef MULT_SHARE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int PERIOD = LAT + 1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic [3:0]  ack;
  logic [15:0] p;
  logic [1:0]  p_id;
  logic        busy;

  int n_tests;
  int n_fail;

  logic [7:0]  four_a [4] = '{8'd10, 8'd16, 8'd200, 8'd7};
  logic [7:0]  four_b [4] = '{8'd10, 8'd16, 8'd3, 8'd9};
  logic [15:0] four_p [4] = '{16'h0064, 16'h0100, 16'h0258, 16'h003F};

  mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .ack    (ack),
    .p      (p),
    .p_id   (p_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int port, input logic [7:0] a, input logic [7:0] b);
    a_flat[port*8 +: 8] = a;
    b_flat[port*8 +: 8] = b;
  endtask

  // Advance on falling edges until ack is seen; n = edges waited, -1 on timeout.
  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (ack != 4'b0) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_tests++; if (p !== 16'h0) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p); end
    n_tests++; if (p_id !== 2'd0) begin n_fail++; $display("FAIL reset_p_id: got %0d want 0", p_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n;
    set_ops(0, 8'd12, 8'd13);
    req = 4'b0001;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_calc: got %b want 1", busy); end
    n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL single_early_ack: got %b want 0000", ack); end
    wait_ack(8, n);
    n_tests++; if (n !== LAT - 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", n + 1, LAT); end
    n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
    n_tests++; if (p !== 16'h009C) begin n_fail++; $display("FAIL single_p: got %h want 009c", p); end
    n_tests++; if (p_id !== 2'd0) begin n_fail++; $display("FAIL single_p_id: got %0d want 0", p_id); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_resp: got %b want 1", busy); end
    req = 4'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || ack !== 4'b0) begin n_fail++; $display("FAIL single_after: busy %b ack %b want 0 0000", busy, ack); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] exp_ack;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_ops(k, four_a[k], four_b[k]);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_ack = 4'b0001 << k;
      wait_ack(12, n);
      n_tests++; if (n !== ((k == 0) ? LAT : PERIOD)) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, n, (k == 0) ? LAT : PERIOD); end
      n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack%0d: got %b want %b", k, ack, exp_ack); end
      n_tests++; if (p !== four_p[k]) begin n_fail++; $display("FAIL b2b_p%0d: got %h want %h", k, p, four_p[k]); end
      n_tests++; if (p_id !== 2'(k)) begin n_fail++; $display("FAIL b2b_p_id%0d: got %0d want %0d", k, p_id, k); end
      req[k] = 1'b0;
    end
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int n;
    int          v_port [4] = '{1, 2, 3, 0};
    logic [7:0]  v_a    [4] = '{8'd255, 8'd0, 8'd1, 8'd100};
    logic [7:0]  v_b    [4] = '{8'd255, 8'd200, 8'd255, 8'd7};
    logic [15:0] v_p    [4] = '{16'hFE01, 16'h0000, 16'h00FF, 16'h02BC};
    logic [3:0]  exp_ack;
    for (int i = 0; i < 4; i++) begin
      set_ops(v_port[i], v_a[i], v_b[i]);
      req = 4'b0001 << v_port[i];
      exp_ack = 4'b0001 << v_port[i];
      wait_ack(10, n);
      n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL bound_latency%0d: got %0d want %0d", i, n, LAT); end
      n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL bound_ack%0d: got %b want %b", i, ack, exp_ack); end
      n_tests++; if (p !== v_p[i]) begin n_fail++; $display("FAIL bound_p%0d: got %h want %h", i, p, v_p[i]); end
      req = 4'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_ops(2, 8'd5, 8'd6);
    req = 4'b0100;
    wait_ack(10, n);
    n_tests++; if (n !== LAT || p !== 16'h001E) begin n_fail++; $display("FAIL mid_setup: got n=%0d p=%h want n=%0d p=001e", n, p, LAT); end
    req = 4'b0;
    @(negedge clk);
    set_ops(3, 8'd9, 8'd9);
    req = 4'b1100;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_calc: got %b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL mid_ack: got %b want 0000", ack); end
    n_tests++; if (p !== 16'h0) begin n_fail++; $display("FAIL mid_p: got %h want 0000", p); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_tests++; if (p_id !== 2'd0) begin n_fail++; $display("FAIL mid_p_id: got %0d want 0", p_id); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(10, n);
    n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL mid_post_latency: got %0d want %0d", n, LAT); end
    n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL mid_post_ack: got %b want 0100", ack); end
    n_tests++; if (p !== 16'h001E || p_id !== 2'd2) begin n_fail++; $display("FAIL mid_post_p: got %h/%0d want 001e/2", p, p_id); end
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int n;
    int exp_port;
    logic [3:0]  exp_ack;
    logic [15:0] exp_p;
    set_ops(0, 8'd3, 8'd5);
    set_ops(2, 8'd20, 8'd11);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      exp_port = (k % 2 == 0) ? 0 : 2;
      exp_ack  = 4'b0001 << exp_port;
      exp_p    = (exp_port == 0) ? 16'h000F : 16'h00DC;
      wait_ack(12, n);
      n_tests++; if (n < 0) begin n_fail++; $display("FAIL fair_timeout%0d: got none want ack", k); end
      if (k == 2) begin
        n_tests++; if (n !== PERIOD) begin n_fail++; $display("FAIL fair_spacing: got %0d want %0d", n, PERIOD); end
      end
      n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL fair_ack%0d: got %b want %b", k, ack, exp_ack); end
      n_tests++; if (p !== exp_p) begin n_fail++; $display("FAIL fair_p%0d: got %h want %h", k, p, exp_p); end
      if (exp_port == 0) begin
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
      end
    end
    req = 4'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0;
    a_flat  = '0;
    b_flat  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 8x8 unsigned multiplier (`Multiplier_8`) among up to eight requesters in the smart-home datapath, such as sensor scaling, power estimation and timer math. Operands are captured into registers on grant. The product is registered and returned with a one-cycle acknowledge pulse tagged with the requester index. This keeps the multiplier off every requester's critical path and removes the need for one multiplier instance per client.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, 2: index width, equal to `$clog2(NUM_REQ)`; minimum 1.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `a_flat`  in  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- `b_flat`  in  8*NUM_REQ  operand B, packed the same way.
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse marking the result valid for that requester.
- `p`  out  16  registered unsigned product; holds its value until the next result.
- `p_id`  out  ID_W  index of the requester that owns `p`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CALC, (STAGE), RESP.
- IDLE:
  - If any `req` is high, pick the winner by round robin and latch its A, B and index.
  - Move to CALC.
  - With no request, stay in IDLE.
- CALC:
  - The latched operands drive `Multiplier_8`.
  - Go to RESP, or to STAGE when the pipeline macro is enabled.
- RESP:
  - Load `p` and `p_id`, assert `ack[p_id]` for exactly this cycle, then return to IDLE.
- Round robin:
  - The search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `last_grant` updates on every grant.
  - After reset `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- Requester protocol:
  - Hold `req` high with stable operands until `ack` is seen.
  - `req` must be low in the cycle after `ack`. A `req` still high in that cycle is a new request.
  - Operand changes after the grant cycle are ignored.
  - Dropping `req` before `ack` does not cancel the operation; the `ack` still fires.
- Arithmetic:
  - Unsigned 8x8 multiply to a full 16-bit result; no truncation and no overflow.
  - Maximum result is 255*255 = 0xFE01.
- Reset values: state IDLE, `ack` 0, `p` 0x0000, `p_id` 0, `busy` 0, `last_grant` NUM_REQ-1.
- Reset mid-operation: the operation is abandoned with no `ack`, and all outputs return to their reset values asynchronously.

## Timing
- Request sampled in IDLE at cycle t: CALC at t+1, RESP (`ack`, `p` valid) at t+2.
- Latency is 2 cycles, or 3 with the macro.
- Throughput is one result per 3 cycles (4 with the macro), because IDLE is always visited between operations.
- `busy` rises at t+1 and falls after RESP.
- `ack` is never asserted for more than one requester, and never in two consecutive cycles.

## Configuration
- `MULT_SHARE_PIPE_EN`:
  - When defined, a STAGE state sits between CALC and RESP. The multiplier output is registered in STAGE, which relaxes timing.
  - Latency becomes 3 cycles and the period 4 cycles.
  - When undefined, STAGE does not exist: latency 2, period 3.
  - Results are identical in both builds.

## Structure
- Package `mult_share_pkg`:
  - State enum / localparams for IDLE, CALC, STAGE, RESP.
  - `MAX_REQ = 8` and `OPW = 8`.
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: `req` and `last_grant`. Outputs: `any` and `idx`.
- The multiplier itself is a single instance of the existing `Multiplier_8`.

## Test plan
- Single request, `req[0]`, A=12, B=13 → `ack[0]` at t+2, `p`=0x009C, `p_id`=0, `busy` high for t+1..t+2.
- All four requesters held high from reset → grants in order 0,1,2,3, `ack` spaced 3 cycles apart, each `p` matching its own operands.
- Boundary operands → 255*255 gives `p`=0xFE01; 0*200 gives `p`=0x0000; 1*255 gives `p`=0x00FF.
- Fairness → `req[0]` re-requests every time while `req[2]` is held continuously; grants alternate 0,2,0,2 and requester 0 is never granted twice in a row.
- Reset asserted during CALC → no `ack`, `p`=0, `busy`=0 immediately; the next request after reset is granted to the lowest-index requesting port.
- With `MULT_SHARE_PIPE_EN` defined, A=100, B=7 → `ack` at t+3, `p`=0x02BC; back-to-back requests spaced 4 cycles apart.
